// File: rtl/spm_test_master_pkg.sv
// Shared widths and FSM encoding for the SPM write/read-back tester.
// Pure declarations: no logic, no latency, no flow control.
package spm_test_master_pkg;

  localparam int SPM_WORDS = 64;
  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 8;
  localparam int BE_W      = 4;
  localparam int BYTE_W    = 8;
  localparam int IDX_W     = 6;
  localparam int CNT_W     = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/spm_pattern_gen.sv
// Seed XOR word index replicated into every byte lane; combinational, zero latency.
// No flow control: the output tracks seed_i/idx_i within the same cycle.
module spm_pattern_gen
  import spm_test_master_pkg::*;
(
  input  logic [DATA_W-1:0] seed_i,
  input  logic [IDX_W-1:0]  idx_i,
  output logic [DATA_W-1:0] data_o
);

  logic [BYTE_W-1:0] idx_byte;

  assign idx_byte = {{(BYTE_W - IDX_W){1'b0}}, idx_i};
  assign data_o   = seed_i ^ {4{idx_byte}};

endmodule

// File: rtl/spm_test_master.sv
// Writes a seeded pattern to all SPM words, reads it back and counts mismatches.
// Run takes 129 cycles after start; start while busy is ignored, abort returns to IDLE.
module spm_test_master
  import spm_test_master_pkg::*;
#(
  parameter int WORDS = SPM_WORDS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              io_start,
  input  logic              io_abort,
  input  logic [DATA_W-1:0] io_seed,
  output logic [DATA_W-1:0] io_M_Data,
  output logic [ADDR_W-1:0] io_M_Addr,
  output logic [BE_W-1:0]   io_M_ByteEn,
  output logic              io_M_We,
  input  logic [DATA_W-1:0] io_S_Data,
  output logic              io_busy,
  output logic              io_done,
  output logic              io_pass,
  output logic [CNT_W-1:0]  io_errCount,
  output logic [ADDR_W-1:0] io_firstErrAddr
);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]  seed_q, seed_d;
  logic [CNT_W-1:0]   err_q, err_d;
  logic [ADDR_W-1:0]  first_q, first_d;
  logic               pass_q, pass_d;

  logic [DATA_W-1:0]  pat;
  logic [ADDR_W-1:0]  word_addr;
  logic               last_word;
  logic               mismatch;

  spm_pattern_gen u_pattern_gen (
    .seed_i (seed_q),
    .idx_i  (idx_q),
    .data_o (pat)
  );

  assign word_addr = {idx_q, 2'b00};
  assign last_word = (idx_q == IDX_W'(WORDS - 1));
  assign mismatch  = (state_q == ST_READ) && (io_S_Data != pat);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (io_start) state_d = ST_WRITE;
      ST_WRITE: begin
        if (io_abort)       state_d = ST_IDLE;
        else if (last_word) state_d = ST_READ;
      end
      ST_READ: begin
        if (io_abort)       state_d = ST_IDLE;
        else if (last_word) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    io_M_Data   = '0;
    io_M_Addr   = '0;
    io_M_ByteEn = '0;
    io_M_We     = 1'b0;
    io_busy     = 1'b0;
    io_done     = 1'b0;
    case (state_q)
      ST_WRITE: begin
        io_M_Data   = pat;
        io_M_Addr   = word_addr;
        io_M_ByteEn = '1;
        io_M_We     = 1'b1;
        io_busy     = 1'b1;
      end
      ST_READ: begin
        io_M_Addr = word_addr;
        io_busy   = 1'b1;
      end
      ST_DONE:  io_done = 1'b1;
      default: ;
    endcase
  end

  // Result registers hold across IDLE/DONE and are only cleared by an accepted start.
  always_comb begin
    idx_d   = idx_q;
    seed_d  = seed_q;
    err_d   = err_q;
    first_d = first_q;
    pass_d  = pass_q;
    case (state_q)
      ST_IDLE: begin
        if (io_start) begin
          seed_d  = io_seed;
          idx_d   = '0;
          err_d   = '0;
          first_d = '0;
          pass_d  = 1'b0;
        end
      end
      ST_WRITE: begin
        idx_d = io_abort ? '0 : idx_q + 1'b1;
      end
      ST_READ: begin
        idx_d = io_abort ? '0 : idx_q + 1'b1;
        if (mismatch) begin
          if (err_q != CNT_W'(WORDS)) err_d = err_q + 1'b1;
          if (err_q == '0)            first_d = word_addr;
        end
        if (last_word && !io_abort) pass_d = (err_q == '0) && !mismatch;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q   <= '0;
      seed_q  <= '0;
      err_q   <= '0;
      first_q <= '0;
      pass_q  <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      seed_q  <= seed_d;
      err_q   <= err_d;
      first_q <= first_d;
      pass_q  <= pass_d;
    end
  end

  assign io_pass         = pass_q;
  assign io_errCount     = err_q;
  assign io_firstErrAddr = first_q;

endmodule

// File: tb/tb_spm_test_master.sv
// Directed bench for spm_test_master: table of full runs plus abort, restart and reset sequences.
module tb_spm_test_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        io_start;
  logic        io_abort;
  logic [31:0] io_seed;
  logic [31:0] io_M_Data;
  logic [7:0]  io_M_Addr;
  logic [3:0]  io_M_ByteEn;
  logic        io_M_We;
  logic [31:0] io_S_Data;
  logic        io_busy;
  logic        io_done;
  logic        io_pass;
  logic [6:0]  io_errCount;
  logic [7:0]  io_firstErrAddr;

  always #5 clk = ~clk;

  spm_test_master dut (
    .clk             (clk),
    .reset           (reset),
    .io_start        (io_start),
    .io_abort        (io_abort),
    .io_seed         (io_seed),
    .io_M_Data       (io_M_Data),
    .io_M_Addr       (io_M_Addr),
    .io_M_ByteEn     (io_M_ByteEn),
    .io_M_We         (io_M_We),
    .io_S_Data       (io_S_Data),
    .io_busy         (io_busy),
    .io_done         (io_done),
    .io_pass         (io_pass),
    .io_errCount     (io_errCount),
    .io_firstErrAddr (io_firstErrAddr)
  );

  // SPM model: mode 0 functional, 1 word 10 reads all-ones, 2 every read returns zero.
  logic [31:0] mem [0:63];
  int          fault_mode;

  always @(posedge clk) begin
    if (io_M_We && io_M_ByteEn == 4'hF) mem[io_M_Addr[7:2]] <= io_M_Data;
  end

  always_comb begin
    io_S_Data = mem[io_M_Addr[7:2]];
    if (fault_mode == 1 && io_M_Addr[7:2] == 6'd10) io_S_Data = 32'hFFFF_FFFF;
    if (fault_mode == 2) io_S_Data = 32'h0;
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Values captured by run()
  int          done_k, busy_n, done_n;
  logic        pass_at_done;
  logic [31:0] w5_dat;
  logic [7:0]  w5_addr;
  logic [3:0]  w5_be;
  logic        w5_we;
  logic [31:0] r1_dat;
  logic [7:0]  r1_addr;
  logic [3:0]  r1_be;
  logic        r1_we;
  logic [63:0] rst_outs;
  logic [63:0] abort_outs;

  task automatic run(input logic [31:0] seed, input int mode, input int repulse_k,
                     input int abort_k, input int reset_k);
    done_k = 0; busy_n = 0; done_n = 0; pass_at_done = 1'b0;
    rst_outs = '1; abort_outs = '1;
    @(posedge clk); #1;
    fault_mode = mode;
    io_seed    = seed;
    io_start   = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      io_start = (k == repulse_k);
      io_seed  = ~seed;
      io_abort = (k == abort_k);
      if (k == reset_k + 1) reset = 1'b0;
      if (k == reset_k) begin
        reset = 1'b1;
        #1;
        rst_outs = {io_M_We, io_M_ByteEn, io_busy, io_done, io_pass, io_errCount,
                    io_firstErrAddr, io_M_Addr, io_M_Data};
      end
      @(negedge clk);
      if (io_busy) busy_n++;
      if (io_done) begin
        done_n++;
        if (done_k == 0) begin
          done_k = k;
          pass_at_done = io_pass;
        end
      end
      if (k == 6) begin
        w5_dat = io_M_Data; w5_addr = io_M_Addr; w5_be = io_M_ByteEn; w5_we = io_M_We;
      end
      if (k == 66) begin
        r1_dat = io_M_Data; r1_addr = io_M_Addr; r1_be = io_M_ByteEn; r1_we = io_M_We;
      end
      if (k == abort_k + 1)
        abort_outs = {55'h0, io_busy, io_done, io_pass, io_M_We, io_M_ByteEn, io_errCount == 7'd0};
    end
  endtask

  typedef struct {
    logic [31:0] seed;
    int          mode;
    logic [31:0] exp_w5;
    logic [6:0]  exp_err;
    logic [7:0]  exp_first;
    logic        exp_pass;
  } vec_t;

  vec_t vecs [5];

  initial begin
    vecs[0] = '{32'h0000_0000, 0, 32'h0505_0505, 7'd0,  8'h00, 1'b1};
    vecs[1] = '{32'hA5A5_A5A5, 1, 32'hA0A0_A0A0, 7'd1,  8'h28, 1'b0};
    vecs[2] = '{32'h0000_0000, 2, 32'h0505_0505, 7'd63, 8'h04, 1'b0};
    vecs[3] = '{32'h1234_5678, 0, 32'h1731_537D, 7'd0,  8'h00, 1'b1};
    vecs[4] = '{32'hFFFF_FFFF, 2, 32'hFAFA_FAFA, 7'd64, 8'h00, 1'b0};

    reset = 1'b1; io_start = 1'b0; io_abort = 1'b0; io_seed = '0; fault_mode = 0;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs",
        {io_M_We, io_M_ByteEn, io_busy, io_done, io_pass, io_errCount, io_firstErrAddr,
         io_M_Addr, io_M_Data}, 64'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int v = 0; v < 5; v++) begin
      run(vecs[v].seed, vecs[v].mode, 0, 0, 0);
      chk($sformatf("v%0d_done_cycle", v), done_k, 129);
      chk($sformatf("v%0d_done_pulses", v), done_n, 1);
      chk($sformatf("v%0d_busy_cycles", v), busy_n, 128);
      chk($sformatf("v%0d_w5_bus", v), {w5_we, w5_be, w5_addr, w5_dat},
          {1'b1, 4'hF, 8'h14, vecs[v].exp_w5});
      chk($sformatf("v%0d_mem5", v), mem[5], vecs[v].exp_w5);
      chk($sformatf("v%0d_r1_bus", v), {r1_we, r1_be, r1_addr, r1_dat},
          {1'b0, 4'h0, 8'h04, 32'h0});
      chk($sformatf("v%0d_pass_at_done", v), pass_at_done, vecs[v].exp_pass);
      chk($sformatf("v%0d_err", v), io_errCount, vecs[v].exp_err);
      chk($sformatf("v%0d_first", v), io_firstErrAddr, vecs[v].exp_first);
      chk($sformatf("v%0d_pass_hold", v), io_pass, vecs[v].exp_pass);
    end

    // Abort in READ at start+70 after a passing run: idle, no done, pass cleared.
    run(32'h0000_0000, 0, 0, 70, 0);
    chk("abort_state", abort_outs, {55'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1});
    chk("abort_no_done", done_n, 0);
    chk("abort_busy_cycles", busy_n, 70);
    chk("abort_pass_hold", io_pass, 1'b0);

    run(32'hA5A5_A5A5, 1, 0, 0, 0);
    chk("post_abort_done_cycle", done_k, 129);
    chk("post_abort_err", io_errCount, 7'd1);
    chk("post_abort_first", io_firstErrAddr, 8'h28);

    // Start re-pulsed 20 cycles into the run must not restart it.
    run(32'h0000_0000, 2, 20, 0, 0);
    chk("repulse_done_cycle", done_k, 129);
    chk("repulse_done_pulses", done_n, 1);
    chk("repulse_err", io_errCount, 7'd63);

    // Reset mid-write clears every output at once; no done follows.
    run(32'h1234_5678, 0, 0, 0, 30);
    chk("midrun_reset_outputs", rst_outs, 64'h0);
    chk("midrun_reset_no_done", done_n, 0);
    chk("midrun_reset_busy", busy_n, 29);

    run(32'hFFFF_FFFF, 2, 0, 0, 0);
    chk("post_reset_done_cycle", done_k, 129);
    chk("post_reset_err", io_errCount, 7'd64);
    chk("post_reset_pass", io_pass, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/spm_test_master.md
SPM_TEST_MASTER -- requirements
Module: spm_test_master

Interface
REQ-001 Parameter: WORDS, default 64, number of 32-bit SPM words exercised (fixed at 64; address field 8 bits, byte-addressed).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 io_start  input  1  one-cycle request to begin a write/read-back run.
REQ-005 io_abort  input  1  terminates a run in progress.
REQ-006 io_seed  input  32  pattern seed, sampled on accepted start.
REQ-007 io_M_Data  output  32  SPM write data.
REQ-008 io_M_Addr  output  8  SPM byte address; bits [1:0] always 0.
REQ-009 io_M_ByteEn  output  4  SPM byte lane enables.
REQ-010 io_M_We  output  1  SPM write enable.
REQ-011 io_S_Data  input  32  SPM read data, combinational from io_M_Addr in the same cycle.
REQ-012 io_busy  output  1  high while in WRITE or READ.
REQ-013 io_done  output  1  one-cycle pulse at run completion (not on abort).
REQ-014 io_pass  output  1  high when last completed run had zero mismatches.
REQ-015 io_errCount  output  7  mismatch count of current/last run, 0..64.
REQ-016 io_firstErrAddr  output  8  byte address of first mismatch in last run; 0 if none.

Function
REQ-017 FSM states IDLE, WRITE, READ, DONE; reset state IDLE.
REQ-018 IDLE: io_start high -> capture seed, clear errCount/firstErrAddr/pass, word index i=0, enter WRITE next cycle.
REQ-019 Pattern: data(i) = seed XOR {4{2'b00,i[5:0]}} (index byte replicated in all four lanes).
REQ-020 WRITE: per cycle drive Addr={i,2'b00}, Data=data(i), ByteEn=4'hF, We=1; i increments; after i=63 go to READ with i=0.
REQ-021 READ: per cycle drive Addr={i,2'b00}, ByteEn=4'h0, We=0; compare io_S_Data with data(i) the same cycle; after i=63 go to DONE.
REQ-022 Mismatch: errCount increments (never exceeds 64); firstErrAddr recorded only on first mismatch of the run.
REQ-023 DONE: one cycle; done=1, pass=(errCount==0); next state IDLE.
REQ-024 Timing: start accepted at cycle n -> writes n+1..n+64, reads n+65..n+128, done at n+129; busy high n+1..n+128.
REQ-025 Outside WRITE: We=0, ByteEn=4'h0; Data=0 outside WRITE; Addr=0 in IDLE and DONE.
REQ-026 io_start while not IDLE is ignored.
REQ-027 io_abort in WRITE or READ -> IDLE next cycle, no done pulse, pass=0, errCount retained; io_abort has priority over io_start in the same cycle; io_abort in IDLE or DONE is ignored.
REQ-028 pass, errCount, firstErrAddr hold their values until the next accepted start.

Reset
REQ-029 Reset asserted at any time (including mid-run) forces IDLE, i=0, all outputs 0 (We=0, ByteEn=0, busy=0, done=0, pass=0, errCount=0, firstErrAddr=0).
REQ-030 The first start is accepted no earlier than the first clock edge after reset deassertion.

Structure
REQ-031 Shared package: WORDS, data width 32, address width 8, ByteEn width 4, FSM state enumeration.
REQ-032 One sub-module spm_pattern_gen (seed, index -> 32-bit data), instantiated once and shared by WRITE and READ.

Verification
REQ-033 Start with seed=0x00000000 against a functional SPM model -> 64 writes (word 5 = 0x05050505), then 64 reads; done at start+129, pass=1, errCount=0.
REQ-034 Model forces word 10 read = 0xFFFFFFFF, seed=0xA5A5A5A5 -> errCount=1, firstErrAddr=0x28, pass=0.
REQ-035 Model returns all-zero on every read, seed=0 -> only word 0 matches; errCount=63, firstErrAddr=0x04.
REQ-036 Assert abort at start+70 -> IDLE at start+71, no done pulse, busy=0, pass=0; a following start runs to completion normally.
REQ-037 Assert reset at start+30 -> all outputs 0 immediately; start re-pulsed at start 20 cycles into the run -> ignored (no restart, done still at original start+129).
